// File: rtl/load_issue_sequencer.sv
// Load issue sequencer: splits each load instruction into one meta record and a
// series of AXI bursts (<=256 beats, never crossing 4 KB). Optional counters: LOAD_SEQ_PERF_CNT_EN.
module load_issue_sequencer #(
    parameter int AxiDataWidth = 64,
    parameter int AxiAddrWidth = 64,
    parameter int LenWidth     = 32,
    parameter int MaxInflight  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [AxiAddrWidth-1:0]          req_addr_i,
    input  logic [LenWidth-1:0]              req_bytes_i,
    output logic                             meta_valid_o,
    input  logic                             meta_ready_i,
    output logic [AxiAddrWidth-1:0]          meta_addr_o,
    output logic [LenWidth-1:0]              meta_beats_o,
    output logic                             txn_valid_o,
    input  logic                             txn_ready_i,
    output logic [AxiAddrWidth-1:0]          txn_addr_o,
    output logic [7:0]                       txn_len_o,
    output logic                             txn_last_o,
    input  logic                             done_i,
    output logic [$clog2(MaxInflight+1)-1:0] inflight_o,
    output logic                             busy_o
`ifdef LOAD_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_txn_o,
    output logic [31:0]                      perf_stall_o
`endif
);

    localparam int BB    = AxiDataWidth / 8;
    localparam int BbLog = $clog2(BB);
    localparam int CntW  = $clog2(MaxInflight + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_META  = 2'd1,
        S_BURST = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_next_state;
    logic [CntW-1:0]         r_inflight;
    logic [AxiAddrWidth-1:0] r_cur_addr;
    logic [LenWidth-1:0]     r_rem_beats;

    logic                    w_req_ready;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_meta_hs;
    logic                    w_txn_hs;
    logic                    w_inc;
    logic                    w_dec;
    logic [LenWidth:0]       w_bytes_round;
    logic [LenWidth-1:0]     w_req_beats;
    logic [12:0]             w_page_off;
    logic [12:0]             w_page_beats;
    logic [12:0]             w_rem_cap;
    logic [12:0]             w_nb;
    logic                    w_last;

    assign w_req_ready   = (r_state == S_IDLE) && (r_inflight < CntW'(MaxInflight));
    assign w_accept      = req_valid_i & w_req_ready;
    assign w_start       = w_accept & (req_bytes_i != {LenWidth{1'b0}});
    assign w_meta_hs     = (r_state == S_META) & meta_ready_i;
    assign w_txn_hs      = (r_state == S_BURST) & txn_ready_i;

    // Rounding in one extra bit so a byte count near 2^LenWidth cannot wrap.
    assign w_bytes_round = {1'b0, req_bytes_i} + (LenWidth+1)'(BB - 1);
    assign w_req_beats   = LenWidth'(w_bytes_round >> BbLog);

    // Burst size: capped by AXI max length, remaining beats and distance to the 4 KB page end.
    assign w_page_off    = {1'b0, r_cur_addr[11:0]};
    assign w_page_beats  = (13'h1000 - w_page_off) >> BbLog;
    assign w_rem_cap     = (r_rem_beats > LenWidth'(256)) ? 13'd256 : r_rem_beats[12:0];
    assign w_nb          = (w_rem_cap < w_page_beats) ? w_rem_cap : w_page_beats;
    assign w_last        = (LenWidth'(w_nb) == r_rem_beats);

    assign w_inc         = w_start;
    assign w_dec         = done_i & (r_inflight != {CntW{1'b0}});

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next_state = S_META;
                else         w_next_state = S_IDLE;
            end
            S_META: begin
                if (w_meta_hs) w_next_state = S_BURST;
                else           w_next_state = S_META;
            end
            S_BURST: begin
                if (w_txn_hs && w_last) w_next_state = S_IDLE;
                else                    w_next_state = S_BURST;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the registered state and datapath.
    always_comb begin
        req_ready_o  = 1'b0;
        meta_valid_o = 1'b0;
        txn_valid_o  = 1'b0;
        txn_last_o   = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready_o = w_req_ready;
                busy_o      = 1'b0;
            end
            S_META: begin
                meta_valid_o = 1'b1;
            end
            S_BURST: begin
                txn_valid_o = 1'b1;
                txn_last_o  = w_last;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign meta_addr_o  = r_cur_addr;
    assign meta_beats_o = r_rem_beats;
    assign txn_addr_o   = r_cur_addr;
    assign txn_len_o    = 8'(w_nb - 13'd1);
    assign inflight_o   = r_inflight;

    // Address and beat bookkeeping for the instruction being issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cur_addr  <= {AxiAddrWidth{1'b0}};
            r_rem_beats <= {LenWidth{1'b0}};
        end else if (w_start) begin
            r_cur_addr  <= req_addr_i;
            r_rem_beats <= w_req_beats;
        end else if (w_txn_hs) begin
            r_cur_addr  <= r_cur_addr + (AxiAddrWidth'(w_nb) << BbLog);
            r_rem_beats <= r_rem_beats - LenWidth'(w_nb);
        end else begin
            r_cur_addr  <= r_cur_addr;
            r_rem_beats <= r_rem_beats;
        end
    end

    // Inflight count: accept and retire in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= {CntW{1'b0}};
        end else if (w_inc && !w_dec) begin
            r_inflight <= r_inflight + CntW'(1);
        end else if (!w_inc && w_dec) begin
            r_inflight <= r_inflight - CntW'(1);
        end else begin
            r_inflight <= r_inflight;
        end
    end

`ifdef LOAD_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_txn;
    logic [31:0] r_perf_stall;

    // Free-running performance counters, wrapping naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_txn   <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            r_perf_txn   <= r_perf_txn + (w_txn_hs ? 32'd1 : 32'd0);
            r_perf_stall <= r_perf_stall + ((txn_valid_o && !txn_ready_i) ? 32'd1 : 32'd0);
        end
    end

    assign perf_txn_o   = r_perf_txn;
    assign perf_stall_o = r_perf_stall;
`endif

    a_done_with_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_i |-> (r_inflight != {CntW{1'b0}}));

    a_req_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_accept |-> ((req_addr_i & AxiAddrWidth'(BB - 1)) == {AxiAddrWidth{1'b0}}));

endmodule

// File: tb/tb_load_issue_sequencer.sv
// Randomized bench for load_issue_sequencer against a queue-based model of
// the expected meta and burst stream, plus directed literal checks.
module tb_load_issue_sequencer;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic [31:0] req_bytes_i;
    logic        meta_valid_o;
    logic        meta_ready_i;
    logic [63:0] meta_addr_o;
    logic [31:0] meta_beats_o;
    logic        txn_valid_o;
    logic        txn_ready_i;
    logic [63:0] txn_addr_o;
    logic [7:0]  txn_len_o;
    logic        txn_last_o;
    logic        done_i;
    logic [2:0]  inflight_o;
    logic        busy_o;
`ifdef LOAD_SEQ_PERF_CNT_EN
    logic [31:0] perf_txn_o;
    logic [31:0] perf_stall_o;
`endif

    load_issue_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_bytes_i  (req_bytes_i),
        .meta_valid_o (meta_valid_o),
        .meta_ready_i (meta_ready_i),
        .meta_addr_o  (meta_addr_o),
        .meta_beats_o (meta_beats_o),
        .txn_valid_o  (txn_valid_o),
        .txn_ready_i  (txn_ready_i),
        .txn_addr_o   (txn_addr_o),
        .txn_len_o    (txn_len_o),
        .txn_last_o   (txn_last_o),
        .done_i       (done_i),
        .inflight_o   (inflight_o),
        .busy_o       (busy_o)
`ifdef LOAD_SEQ_PERF_CNT_EN
        ,
        .perf_txn_o   (perf_txn_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic        last;
    } txn_t;

    logic [63:0] mq_addr[$];
    logic [31:0] mq_beats[$];
    txn_t        tq[$];
    int          m_inflight;
    logic [31:0] m_perf_txn;
    logic [31:0] m_perf_stall;

    int n_tests;
    int n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_busy();
        return (mq_addr.size() != 0) || (tq.size() != 0);
    endfunction

    function automatic logic m_ready();
        return !m_busy() && (m_inflight < 4);
    endfunction

    // Expected burst list: greedy chunks bounded by 256 beats and the 4 KB page.
    task automatic push_request(input logic [63:0] a, input logic [31:0] b);
        longint unsigned addr = a;
        longint unsigned rem  = (longint'(b) + 7) / 8;
        mq_addr.push_back(a);
        mq_beats.push_back(32'(rem));
        while (rem > 0) begin
            longint unsigned page = (4096 - (addr % 4096)) / 8;
            longint unsigned nb   = rem;
            txn_t t;
            if (nb > 256)  nb = 256;
            if (nb > page) nb = page;
            t.addr = addr;
            t.len  = 8'(nb - 1);
            t.last = (nb == rem);
            tq.push_back(t);
            addr += nb * 8;
            rem  -= nb;
        end
    endtask

    task automatic compare_outputs();
        logic exp_meta = (mq_addr.size() != 0);
        logic exp_txn  = !exp_meta && (tq.size() != 0);
        chk("busy", busy_o, m_busy());
        chk("req_ready", req_ready_o, m_ready());
        chk("inflight", inflight_o, 64'(m_inflight));
        chk("meta_valid", meta_valid_o, exp_meta);
        chk("txn_valid", txn_valid_o, exp_txn);
        if (exp_meta) begin
            chk("meta_addr", meta_addr_o, mq_addr[0]);
            chk("meta_beats", meta_beats_o, mq_beats[0]);
        end
        if (exp_txn) begin
            chk("txn_addr", txn_addr_o, tq[0].addr);
            chk("txn_len", txn_len_o, tq[0].len);
            chk("txn_last", txn_last_o, tq[0].last);
        end
`ifdef LOAD_SEQ_PERF_CNT_EN
        chk("perf_txn", perf_txn_o, m_perf_txn);
        chk("perf_stall", perf_stall_o, m_perf_stall);
`endif
    endtask

    // One clock cycle: drive, check the current outputs, advance, update model.
    task automatic cyc(input logic rv, input logic [63:0] a, input logic [31:0] b,
                       input logic mr, input logic tr, input logic dn);
        logic hs_req, hs_meta, hs_txn, stall, inc, dec;
        req_valid_i  = rv;
        req_addr_i   = a;
        req_bytes_i  = b;
        meta_ready_i = mr;
        txn_ready_i  = tr;
        done_i       = dn;
        compare_outputs();
        hs_req  = rv && m_ready();
        hs_meta = mr && (mq_addr.size() != 0);
        hs_txn  = tr && (mq_addr.size() == 0) && (tq.size() != 0);
        stall   = !tr && (mq_addr.size() == 0) && (tq.size() != 0);
        @(posedge clk_i);
        @(negedge clk_i);
        inc = hs_req && (b != 32'd0);
        dec = dn && (m_inflight > 0);
        if (inc) push_request(a, b);
        m_inflight = m_inflight + int'(inc) - int'(dec);
        if (hs_meta) begin
            void'(mq_addr.pop_front());
            void'(mq_beats.pop_front());
        end
        if (hs_txn) begin
            void'(tq.pop_front());
            m_perf_txn = m_perf_txn + 32'd1;
        end
        if (stall) m_perf_stall = m_perf_stall + 32'd1;
    endtask

    task automatic idle_cyc(input logic mr, input logic tr, input logic dn);
        cyc(1'b0, 64'd0, 32'd0, mr, tr, dn);
    endtask

    task automatic clear_model();
        mq_addr.delete();
        mq_beats.delete();
        tq.delete();
        m_inflight   = 0;
        m_perf_txn   = 32'd0;
        m_perf_stall = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_meta_valid"}, meta_valid_o, 1'b0);
        chk({tag, "_txn_valid"}, txn_valid_o, 1'b0);
        chk({tag, "_txn_last"}, txn_last_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_inflight"}, inflight_o, 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [31:0] rb;
        n_tests = 0;
        n_fail  = 0;
        clear_model();
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = 64'd0;
        req_bytes_i  = 32'd0;
        meta_ready_i = 1'b0;
        txn_ready_i  = 1'b0;
        done_i       = 1'b0;
        #1;
        check_reset_values("por");
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        chk("ready_after_reset", req_ready_o, 1'b1);

        // Aligned 64-byte load.
        cyc(1'b1, 64'h1000, 32'd64, 1'b0, 1'b0, 1'b0);
        chk("a_meta_valid", meta_valid_o, 1'b1);
        chk("a_meta_addr", meta_addr_o, 64'h1000);
        chk("a_meta_beats", meta_beats_o, 64'd8);
        chk("a_inflight", inflight_o, 64'd1);
        idle_cyc(1'b1, 1'b0, 1'b0);
        chk("a_txn_addr", txn_addr_o, 64'h1000);
        chk("a_txn_len", txn_len_o, 64'd7);
        chk("a_txn_last", txn_last_o, 1'b1);
        idle_cyc(1'b0, 1'b1, 1'b0);
        chk("a_idle", busy_o, 1'b0);
        idle_cyc(1'b0, 1'b0, 1'b1);

        // 4 KB crossing.
        cyc(1'b1, 64'h1FF0, 32'd32, 1'b0, 1'b0, 1'b0);
        idle_cyc(1'b1, 1'b0, 1'b0);
        chk("x_txn0_addr", txn_addr_o, 64'h1FF0);
        chk("x_txn0_len", txn_len_o, 64'd1);
        chk("x_txn0_last", txn_last_o, 1'b0);
        idle_cyc(1'b0, 1'b1, 1'b0);
        chk("x_txn1_addr", txn_addr_o, 64'h2000);
        chk("x_txn1_len", txn_len_o, 64'd1);
        chk("x_txn1_last", txn_last_o, 1'b1);
        idle_cyc(1'b0, 1'b1, 1'b0);
        idle_cyc(1'b0, 1'b0, 1'b1);

        // 4096-byte load with five stall cycles on the first burst.
        cyc(1'b1, 64'h0, 32'd4096, 1'b0, 1'b0, 1'b0);
        idle_cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("l_stall_addr", txn_addr_o, 64'h0);
            chk("l_stall_len", txn_len_o, 64'd255);
            chk("l_stall_last", txn_last_o, 1'b0);
            chk("l_stall_valid", txn_valid_o, 1'b1);
            idle_cyc(1'b0, 1'b0, 1'b0);
        end
`ifdef LOAD_SEQ_PERF_CNT_EN
        chk("l_perf_stall", perf_stall_o, 64'd5);
`endif
        chk("l_txn0_addr", txn_addr_o, 64'h0);
        idle_cyc(1'b0, 1'b1, 1'b0);
        chk("l_txn1_addr", txn_addr_o, 64'h800);
        chk("l_txn1_len", txn_len_o, 64'd255);
        chk("l_txn1_last", txn_last_o, 1'b1);
        idle_cyc(1'b0, 1'b1, 1'b0);
        idle_cyc(1'b0, 1'b0, 1'b1);

        // Fill to MaxInflight, then retire and overlap accept with done.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 64'h3000 + 64'(k * 64), 32'd8, 1'b0, 1'b0, 1'b0);
            idle_cyc(1'b1, 1'b0, 1'b0);
            idle_cyc(1'b0, 1'b1, 1'b0);
        end
        chk("f_ready_full", req_ready_o, 1'b0);
        chk("f_inflight_full", inflight_o, 64'd4);
        cyc(1'b1, 64'h3400, 32'd8, 1'b0, 1'b0, 1'b0);
        chk("f_no_accept", inflight_o, 64'd4);
        idle_cyc(1'b0, 1'b0, 1'b1);
        chk("f_ready_after_done", req_ready_o, 1'b1);
        chk("f_inflight_3", inflight_o, 64'd3);
        cyc(1'b1, 64'h40, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("z_inflight", inflight_o, 64'd3);
        chk("z_busy", busy_o, 1'b0);
        chk("z_meta_valid", meta_valid_o, 1'b0);
        cyc(1'b1, 64'h4000, 32'd8, 1'b0, 1'b0, 1'b1);
        chk("f_accept_done", inflight_o, 64'd3);
        chk("f_accept_meta", meta_valid_o, 1'b1);
        idle_cyc(1'b1, 1'b0, 1'b0);
        idle_cyc(1'b0, 1'b1, 1'b0);
        repeat (3) idle_cyc(1'b0, 1'b0, 1'b1);
        chk("f_drained", inflight_o, 64'd0);

        // Reset while a burst is pending.
        cyc(1'b1, 64'h5000, 32'd64, 1'b0, 1'b0, 1'b0);
        idle_cyc(1'b1, 1'b0, 1'b0);
        chk("r_in_burst", txn_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_reset_values("mid");
        clear_model();
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("r_ready", req_ready_o, 1'b1);
        repeat (3) idle_cyc(1'b1, 1'b1, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            ra = {32'd0, $urandom} & ~64'h7;
            if ($urandom_range(0, 3) == 0) ra = ra | 64'hFC0;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 64));
                2:       rb = 32'($urandom_range(1, 4096));
                3:       rb = 32'($urandom_range(4000, 5000));
                default: rb = 32'($urandom_range(1, 600));
            endcase
            cyc(($urandom_range(0, 2) == 0), ra, rb,
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                (m_inflight > 0) && ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
